rf_burst_driver: RTL and testbench

Initiator side of the go/data/finish range-measurement protocol. Buffers a burst of samples loaded over a valid/ready interface. On start, it plays the burst to a range_finder-style responder with correct go/finish framing. It then captures the responder's range and error and presents them as a one-cycle result. It sits between a sample source (host regs or test sequencer) and the range finder.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_sample_buf.sv | 46 ++++
 rtl/rf_burst_driver.sv | 186 ++++++++++++++++++
 tb/tb_rf_burst_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the range-finder burst driver.
package rf_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        GO,
        STREAM,
        FIN,
        CAP,
        DONE
    } rf_state_e;

    // The count must be able to represent a completely full buffer.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rf_sample_buf.sv
// Write-pointer sample buffer: appends samples in order, exposes the fill
// count, and provides one combinational indexed read port.
module rf_sample_buf
    import rf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW = countWidth(DEPTH),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             clear_i,
    input  logic [AW-1:0]    rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic             doWrite;

    assign doWrite   = wr_en_i && (count_q < CW'(DEPTH));
    assign rd_data_o = mem_q[rd_idx_i];
    assign count_o   = count_q;

    // Sample storage carries no reset; only the count decides what is valid.
    always_ff @(posedge clock) begin
        if (doWrite) begin
            mem_q[count_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (doWrite) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/rf_burst_driver.sv
// Initiator for the go/data/finish range protocol: buffers a burst, plays it
// out, then captures range/error. Optional RF_SELFCHECK_EN compares the
// returned range against the driver's own max-min of the played samples.
module rf_burst_driver
    import rf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic                   start,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rf_go,
    output logic                   rf_finish,
    output logic [WIDTH-1:0]       rf_data,
    input  logic [WIDTH-1:0]       rf_range,
    input  logic                   rf_error,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   result_error
);

    localparam int CW = countWidth(DEPTH);
    localparam int AW = $clog2(DEPTH);

    rf_state_e        state_q;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    n_q;
    logic             wr_ready_q;
    logic             busy_q;
    logic             rf_go_q;
    logic             rf_finish_q;
    logic             done_q;
    logic             result_error_q;
    logic [WIDTH-1:0] rf_data_q;
    logic [WIDTH-1:0] result_q;

    logic [CW-1:0]    bufCount;
    logic [CW-1:0]    nBurst;
    logic [AW-1:0]    rdIdx;
    logic [WIDTH-1:0] rdData;
    logic [WIDTH-1:0] firstSample;
    logic             wrAccept;
    logic             clearBuf;
    logic             lastStep;
    logic             capError;

    assign wrAccept = wr_valid && wr_ready_q;
    assign clearBuf = (state_q == DONE);
    assign nBurst   = bufCount + CW'(wrAccept);
    assign lastStep = (n_q == CW'(1)) || (idx_q == n_q - CW'(1));

    // A sample loaded in the same cycle as start into an empty buffer is not
    // in memory yet, so the first sample is bypassed straight from wr_data.
    assign firstSample = (bufCount == '0) ? wr_data : rdData;

    always_comb begin
        rdIdx = '0;
        if ((state_q == GO || state_q == STREAM) && (n_q != CW'(1))) begin
            rdIdx = idx_q[AW-1:0];
        end
    end

`ifdef RF_SELFCHECK_EN
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] expRange;

    assign expRange = max_q - min_q;
    assign capError = rf_error | (rf_range != expRange);
`else
    assign capError = rf_error;
`endif

    rf_sample_buf #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_buf (
        .clock    (clock),
        .reset    (reset),
        .wr_en_i  (wrAccept),
        .wr_data_i(wr_data),
        .clear_i  (clearBuf),
        .rd_idx_i (rdIdx),
        .rd_data_o(rdData),
        .count_o  (bufCount)
    );

    // Outputs are assigned for the state being entered, so every protocol
    // signal is a flop and lines up with the state it belongs to.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            n_q            <= '0;
            wr_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
            rf_go_q        <= 1'b0;
            rf_finish_q    <= 1'b0;
            rf_data_q      <= '0;
            done_q         <= 1'b0;
            result_q       <= '0;
            result_error_q <= 1'b0;
`ifdef RF_SELFCHECK_EN
            min_q          <= '0;
            max_q          <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (nBurst == '0)) begin
                        state_q        <= DONE;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b1;
                        result_error_q <= 1'b1;
                        wr_ready_q     <= 1'b0;
                    end else if (start) begin
                        state_q    <= GO;
                        busy_q     <= 1'b1;
                        rf_go_q    <= 1'b1;
                        rf_data_q  <= firstSample;
                        n_q        <= nBurst;
                        idx_q      <= CW'(1);
                        wr_ready_q <= 1'b0;
`ifdef RF_SELFCHECK_EN
                        min_q      <= firstSample;
                        max_q      <= firstSample;
`endif
                    end else begin
                        wr_ready_q <= (nBurst < CW'(DEPTH));
                    end
                end
                GO, STREAM: begin
                    rf_go_q   <= 1'b0;
                    rf_data_q <= rdData;
                    if (lastStep) begin
                        state_q     <= FIN;
                        rf_finish_q <= 1'b1;
                    end else begin
                        state_q <= STREAM;
                        idx_q   <= idx_q + CW'(1);
                    end
`ifdef RF_SELFCHECK_EN
                    if (rdData < min_q) min_q <= rdData;
                    if (rdData > max_q) max_q <= rdData;
`endif
                end
                FIN: begin
                    rf_finish_q <= 1'b0;
                    state_q     <= CAP;
                end
                CAP: begin
                    result_q       <= rf_range;
                    result_error_q <= capError;
                    done_q         <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    wr_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_ready     = wr_ready_q;
    assign busy         = busy_q;
    assign count        = bufCount;
    assign rf_go        = rf_go_q;
    assign rf_finish    = rf_finish_q;
    assign rf_data      = rf_data_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_error = result_error_q;

endmodule

// File: tb/tb_rf_burst_driver.sv
// Scoreboard bench for rf_burst_driver with a range-finder responder stub.
module tb_rf_burst_driver;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_ready;
    logic             start = 1'b0;
    logic             busy;
    logic [$clog2(DEPTH):0] count;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_data;
    logic [WIDTH-1:0] rf_range;
    logic             rf_error;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_error;

    typedef struct {
        logic [15:0] result;
        logic        err;
        int          doneCyc;
        logic [15:0] goData;
        logic [15:0] finData;
        logic        noProto;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   doneCount = 0;
    int   protoErr = 0;
    logic errForce = 1'b0;

    rf_burst_driver #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .start       (start),
        .busy        (busy),
        .count       (count),
        .rf_go       (rf_go),
        .rf_finish   (rf_finish),
        .rf_data     (rf_data),
        .rf_range    (rf_range),
        .rf_error    (rf_error),
        .done        (done),
        .result      (result),
        .result_error(result_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Responder stub: range = max - min of samples from go through finish,
    // presented the cycle after finish is sampled.
    always @(posedge clock) begin : stub
        logic [15:0] lo, hi, sLo, sHi;
        logic        active;
        if (!reset) begin
            rf_range <= '0;
            rf_error <= 1'b0;
            sLo = '0;
            sHi = '0;
            active = 1'b0;
        end else if (rf_go || active) begin
            lo = rf_go ? rf_data : ((rf_data < sLo) ? rf_data : sLo);
            hi = rf_go ? rf_data : ((rf_data > sHi) ? rf_data : sHi);
            sLo = lo;
            sHi = hi;
            active = 1'b1;
            if (rf_finish) begin
                rf_range <= hi - lo;
                rf_error <= errForce;
                active = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks protocol framing.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            if (rf_go && rf_finish) protoErr++;
            if ((rf_go || rf_finish) && (sbQ.size() == 0 || sbQ[0].noProto)) protoErr++;
            if (rf_go && sbQ.size() > 0) checkOutput("go_data", rf_data, sbQ[0].goData);
            if (rf_finish && sbQ.size() > 0) checkOutput("fin_data", rf_data, sbQ[0].finData);
            if (done) begin
                doneCount++;
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("result", result, e.result);
                    checkOutput("result_error", result_error, e.err);
                    checkOutput("done_cycle", cyc, e.doneCyc);
                end
            end
        end
    end

    task automatic loadOne(input logic [15:0] d);
        @(negedge clock);
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
    endtask

    // Issues start and pushes the hand-computed expectation; done is due
    // max(n,2)+2 cycles after the start cycle, or the next cycle if empty.
    task automatic applyStimulus(input logic withLoad, input logic [15:0] loadData,
                                 input logic [15:0] expResult, input logic expErr,
                                 input int n, input logic [15:0] goData,
                                 input logic [15:0] finData);
        exp_t e;
        @(negedge clock);
        start = 1'b1;
        if (withLoad) begin
            wr_valid = 1'b1;
            wr_data  = loadData;
        end
        e.result  = expResult;
        e.err     = expErr;
        e.doneCyc = cyc + ((n == 0) ? 1 : (((n < 2) ? 2 : n) + 2));
        e.goData  = goData;
        e.finData = finData;
        e.noProto = (n == 0);
        sbQ.push_back(e);
        @(posedge clock);
        #1;
        start    = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int d0;
        d0 = doneCount;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            if (doneCount != d0) break;
        end
        if (doneCount == d0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
        @(negedge clock);
        checkOutput({name, "_count_after"}, count, 0);
        checkOutput({name, "_ready_after"}, wr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d;
        repeat (3) @(negedge clock);
        checkOutput("rst_wr_ready", wr_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_go", rf_go, 0);
        checkOutput("rst_finish", rf_finish, 0);
        checkOutput("rst_rf_data", rf_data, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_result_error", result_error, 0);
        reset = 1'b1;

        $display("[TB] burst of five around the sign boundary");
        loadOne(16'h7FFF); loadOne(16'h8000); loadOne(16'h8001);
        loadOne(16'h7FFE); loadOne(16'h7FFF);
        @(negedge clock);
        checkOutput("t1_count", count, 5);
        applyStimulus(1'b0, 16'h0, 16'h0003, 1'b0, 5, 16'h7FFF, 16'h7FFF);
        waitDone("t1");

        $display("[TB] full-scale range burst");
        loadOne(16'h0100); loadOne(16'h0000); loadOne(16'hFFFF); loadOne(16'h0200);
        applyStimulus(1'b0, 16'h0, 16'hFFFF, 1'b0, 4, 16'h0100, 16'h0200);
        waitDone("t2");

        $display("[TB] start with empty buffer");
        applyStimulus(1'b0, 16'h0, 16'hFFFF, 1'b1, 0, 16'h0, 16'h0);
        waitDone("empty");

        $display("[TB] single sample loaded together with start");
        applyStimulus(1'b1, 16'h1234, 16'h0000, 1'b0, 1, 16'h1234, 16'h1234);
        waitDone("t3");

        $display("[TB] overfill and start while busy");
        for (int i = 1; i <= 8; i++) loadOne(16'(i));
        loadOne(16'h0100);
        @(negedge clock);
        checkOutput("full_wr_ready", wr_ready, 0);
        checkOutput("full_count", count, 8);
        applyStimulus(1'b0, 16'h0, 16'h0007, 1'b0, 8, 16'h0001, 16'h0008);
        repeat (3) @(negedge clock);
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h0100;
        @(posedge clock);
        #1;
        start    = 1'b0;
        wr_valid = 1'b0;
        waitDone("t4");
        d = doneCount;
        repeat (12) @(negedge clock);
        checkOutput("t4_no_extra_done", doneCount, d);

        $display("[TB] reset during stream");
        loadOne(16'h0005); loadOne(16'h0006); loadOne(16'h0007); loadOne(16'h0008);
        applyStimulus(1'b0, 16'h0, 16'h0003, 1'b0, 4, 16'h0005, 16'h0008);
        @(negedge clock);
        @(negedge clock);
        checkOutput("abort_busy_before", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abort_go", rf_go, 0);
        checkOutput("abort_finish", rf_finish, 0);
        checkOutput("abort_count", count, 0);
        checkOutput("abort_busy", busy, 0);
        sbQ.delete();
        reset = 1'b1;
        d = doneCount;
        repeat (10) @(negedge clock);
        checkOutput("abort_no_done", doneCount, d);

        $display("[TB] fresh burst after reset");
        loadOne(16'h0010); loadOne(16'h0020);
        applyStimulus(1'b0, 16'h0, 16'h0010, 1'b0, 2, 16'h0010, 16'h0020);
        waitDone("t5");

        $display("[TB] responder error");
        errForce = 1'b1;
        loadOne(16'h0010); loadOne(16'h0020);
        applyStimulus(1'b0, 16'h0, 16'h0010, 1'b1, 2, 16'h0010, 16'h0020);
        waitDone("t6");
        errForce = 1'b0;

        checkOutput("protocol_violations", protoErr, 0);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
